// File: rtl/sha1_mb_wb.sv
// Wishbone-slave SHA-1 engine: chained 512-bit blocks, one round per clock, 16-word rolling schedule.
// Optional interrupt pending flag enabled with `define SHA1_MB_IRQ_EN (otherwise irq is tied low).
module sha1_mb_wb #(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
  parameter int          AUTO_START   = 1,
  parameter int          BLKCNT_WIDTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy,
  output logic        done,
  output logic        irq
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_FINAL = 2'd3;

  logic [1:0]              state;
  logic [31:0]             h [0:4];
  logic [31:0]             a, b, c, d, e;
  logic [31:0]             w [0:15];
  logic [6:0]              rnd;
  logic [4:0]              wcnt;
  logic [BLKCNT_WIDTH-1:0] blkcnt;
  logic                    done_r, err, irq_pend;

  // Bus handshake: a request is taken when stb & cyc address a word inside the
  // window and no ack is outstanding; ack follows one cycle later for one cycle.
  logic [31:0] off;
  logic        in_win, accept, wr, ctrl_wr, msg_wr, busy_i;
  logic        msg_err, msg_ok, start_req, init_req, abort_req, clr_req;
  logic        start_err, init_err, init_ok, auto_go, go, err_set, final_set;

  always_comb begin
    off       = wbs_adr_i - BASE_ADDRESS;
    in_win    = (off < 32'h28) && (off[1:0] == 2'b00);
    accept    = wbs_stb_i & wbs_cyc_i & in_win & ~wbs_ack_o;
    wr        = accept & wbs_we_i & (wbs_sel_i == 4'hF);
    ctrl_wr   = wr & (off[5:2] == 4'd2);
    msg_wr    = wr & (off[5:2] == 4'd3);
    busy_i    = (state != S_IDLE);
    msg_err   = msg_wr & (busy_i | (wcnt == 5'd16));
    msg_ok    = msg_wr & ~msg_err;
    start_req = ctrl_wr & wbs_dat_i[0];
    init_req  = ctrl_wr & wbs_dat_i[1];
    abort_req = ctrl_wr & wbs_dat_i[2];
    clr_req   = ctrl_wr & wbs_dat_i[3];
    start_err = start_req & (busy_i | (wcnt != 5'd16));
    init_err  = init_req & busy_i;
    init_ok   = init_req & ~busy_i;
    auto_go   = (AUTO_START != 0) & msg_ok & (wcnt == 5'd15);
    go        = ((start_req & ~start_err) | auto_go) & ~abort_req;
    err_set   = msg_err | start_err | init_err;
    final_set = (state == S_FINAL) & ~abort_req;
  end

  // Round datapath; W[t-3], W[t-8], W[t-14], W[t-16] live at t+13, t+8, t+2, t (mod 16).
  logic [3:0]  i0, i3, i8, i14;
  logic [31:0] wx, wt, f, k, temp;

  always_comb begin
    i0  = rnd[3:0];
    i3  = i0 + 4'd13;
    i8  = i0 + 4'd8;
    i14 = i0 + 4'd2;
    wx  = w[i3] ^ w[i8] ^ w[i14] ^ w[i0];
    wt  = (rnd < 7'd16) ? w[i0] : {wx[30:0], wx[31]};
    if (rnd < 7'd20) begin
      f = (b & c) | (~b & d);
      k = 32'h5A827999;
    end else if (rnd < 7'd40) begin
      f = b ^ c ^ d;
      k = 32'h6ED9EBA1;
    end else if (rnd < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
      k = 32'h8F1BBCDC;
    end else begin
      f = b ^ c ^ d;
      k = 32'hCA62C1D6;
    end
    temp = {a[26:0], a[31:27]} + f + e + k + wt;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= S_IDLE;
      h[0]   <= 32'h67452301;
      h[1]   <= 32'hEFCDAB89;
      h[2]   <= 32'h98BADCFE;
      h[3]   <= 32'h10325476;
      h[4]   <= 32'hC3D2E1F0;
      a      <= '0;
      b      <= '0;
      c      <= '0;
      d      <= '0;
      e      <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      rnd    <= '0;
      wcnt   <= '0;
      blkcnt <= '0;
      done_r <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (err_set)      err <= 1'b1;
      else if (clr_req) err <= 1'b0;
      if (final_set)    done_r <= 1'b1;
      else if (clr_req) done_r <= 1'b0;
      // INIT is only honoured when idle, so it never collides with FINAL's H update.
      if (init_ok) begin
        h[0]   <= 32'h67452301;
        h[1]   <= 32'hEFCDAB89;
        h[2]   <= 32'h98BADCFE;
        h[3]   <= 32'h10325476;
        h[4]   <= 32'hC3D2E1F0;
        blkcnt <= '0;
      end
      if (abort_req) begin
        state <= S_IDLE;
        wcnt  <= '0;
        rnd   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (msg_ok) begin
              w[wcnt[3:0]] <= wbs_dat_i;
              wcnt         <= wcnt + 5'd1;
            end
            if (go) state <= S_LOAD;
          end
          S_LOAD: begin
            a     <= h[0];
            b     <= h[1];
            c     <= h[2];
            d     <= h[3];
            e     <= h[4];
            rnd   <= '0;
            state <= S_ROUND;
          end
          S_ROUND: begin
            e     <= d;
            d     <= c;
            c     <= {b[1:0], b[31:2]};
            b     <= a;
            a     <= temp;
            w[i0] <= wt;
            if (rnd == 7'd79) begin
              rnd   <= '0;
              state <= S_FINAL;
            end else begin
              rnd <= rnd + 7'd1;
            end
          end
          default: begin
            h[0]   <= h[0] + a;
            h[1]   <= h[1] + b;
            h[2]   <= h[2] + c;
            h[3]   <= h[3] + d;
            h[4]   <= h[4] + e;
            blkcnt <= blkcnt + 1'b1;
            wcnt   <= '0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef SHA1_MB_IRQ_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                  irq_pend <= 1'b0;
    else if (final_set | err_set)  irq_pend <= 1'b1;
    else if (clr_req)              irq_pend <= 1'b0;
  end
`else
  assign irq_pend = 1'b0;
`endif

  logic [31:0] blk_ext, rdata;

  always_comb begin
    blk_ext = '0;
    blk_ext[BLKCNT_WIDTH-1:0] = blkcnt;
    case (off[5:2])
      4'd0:    rdata = 32'h53484131;
      4'd1:    rdata = 32'h00000002;
      4'd2:    rdata = {16'd0, wcnt, rnd, irq_pend, err, done_r, busy_i};
      4'd4:    rdata = h[0];
      4'd5:    rdata = h[1];
      4'd6:    rdata = h[2];
      4'd7:    rdata = h[3];
      4'd8:    rdata = h[4];
      4'd9:    rdata = blk_ext;
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= accept;
      if (accept) wbs_dat_o <= wbs_we_i ? 32'd0 : rdata;
    end
  end

  assign busy = busy_i;
  assign done = done_r;
  assign irq  = irq_pend;

endmodule

// File: tb/tb_sha1_mb_wb.sv
// Self-checking bench for sha1_mb_wb: register table, known SHA-1 vectors, error,
// reset and abort sequences; read results go through an expected-value queue.
module tb_sha1_mb_wb;

  localparam logic [31:0] BASE   = 32'h30000024;
  localparam logic [31:0] O_CTRL = 32'h08;
  localparam logic [31:0] O_MSG  = 32'h0C;
  localparam logic [31:0] O_BLK  = 32'h24;
`ifdef SHA1_MB_IRQ_EN
  localparam logic [31:0] IRQB    = 32'h8;
  localparam logic [31:0] IRQ_EXP = 32'h1;
`else
  localparam logic [31:0] IRQB    = 32'h0;
  localparam logic [31:0] IRQ_EXP = 32'h0;
`endif

  logic        clk, rst, stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i, dat_o;
  logic        ack, busy, done, irq;

  sha1_mb_wb dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_i),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .busy     (busy),
    .done     (done),
    .irq      (irq)
  );

  // clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          tests, fails;
  logic [31:0] exp_q[$];
  logic [31:0] msg [0:47];
  logic [31:0] dg  [0:1][0:4];

  typedef struct {
    logic [31:0] off;
    logic [31:0] exp;
  } vec_t;
  vec_t rv [0:9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // driver: starts and returns on a falling edge; lat = cycles to ack, 0 if none in 8
  task automatic bus(input logic [31:0] off, input logic w_en, input logic [31:0] data,
                     input logic [3:0] s, output logic [31:0] rd, output int lat);
    int g;
    g = 0;
    while (ack && g < 4) begin
      @(negedge clk);
      g++;
    end
    adr = BASE + off; we = w_en; dat_i = data; sel = s; stb = 1'b1; cyc = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack && lat < 8);
    rd = dat_o;
    if (!ack) lat = 0;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    logic [31:0] rd;
    int lat;
    bus(off, 1'b1, data, 4'hF, rd, lat);
    check($sformatf("wr_ack_%02h", off), lat, 1);
  endtask

  task automatic rd_chk(input logic [31:0] off, input logic [31:0] exp, input string name);
    logic [31:0] rd, e;
    int lat;
    exp_q.push_back(exp);
    bus(off, 1'b0, 32'd0, 4'hF, rd, lat);
    e = exp_q.pop_front();
    check({name, "_ack"}, lat, 1);
    if (lat == 1) check(name, rd, e);
  endtask

  task automatic load_words(input int base, input int n);
    for (int i = 0; i < n; i++) wr(O_MSG, msg[base + i]);
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_falls", {31'd0, busy}, 0);
    check("done_set", {31'd0, done}, 1);
  endtask

  task automatic chk_dig(input int k, input string tag);
    for (int i = 0; i < 5; i++) rd_chk(32'h10 + 4 * i, dg[k][i], $sformatf("%s_d%0d", tag, i));
  endtask

  initial begin
    logic [31:0] rd;
    int lat, cnt;
    tests = 0; fails = 0;

    // vectors
    for (int i = 0; i < 48; i++) msg[i] = 32'd0;
    msg[0]  = 32'h61626380; msg[15] = 32'h00000018;
    msg[16] = 32'h61626364; msg[17] = 32'h62636465; msg[18] = 32'h63646566; msg[19] = 32'h64656667;
    msg[20] = 32'h65666768; msg[21] = 32'h66676869; msg[22] = 32'h6768696A; msg[23] = 32'h68696A6B;
    msg[24] = 32'h696A6B6C; msg[25] = 32'h6A6B6C6D; msg[26] = 32'h6B6C6D6E; msg[27] = 32'h6C6D6E6F;
    msg[28] = 32'h6D6E6F70; msg[29] = 32'h6E6F7071; msg[30] = 32'h80000000; msg[47] = 32'h000001C0;
    dg[0][0] = 32'hA9993E36; dg[0][1] = 32'h4706816A; dg[0][2] = 32'hBA3E2571;
    dg[0][3] = 32'h7850C26C; dg[0][4] = 32'h9CD0D89D;
    dg[1][0] = 32'h84983E44; dg[1][1] = 32'h1C3BD26E; dg[1][2] = 32'hBAAE4AA1;
    dg[1][3] = 32'hF95129E5; dg[1][4] = 32'hE54670F1;
    rv[0] = '{32'h00, 32'h53484131}; rv[1] = '{32'h04, 32'h00000002};
    rv[2] = '{32'h08, 32'h00000000}; rv[3] = '{32'h0C, 32'h00000000};
    rv[4] = '{32'h10, 32'h67452301}; rv[5] = '{32'h14, 32'hEFCDAB89};
    rv[6] = '{32'h18, 32'h98BADCFE}; rv[7] = '{32'h1C, 32'h10325476};
    rv[8] = '{32'h20, 32'hC3D2E1F0}; rv[9] = '{32'h24, 32'h00000000};

    // reset state
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, ack}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_dat", dat_o, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) rd_chk(rv[i].off, rv[i].exp, $sformatf("reg_%02h", rv[i].off));

    // out-of-window and misaligned: never acked
    bus(32'h28, 1'b0, 32'd0, 4'hF, rd, lat);
    check("oob_noack", lat, 0);
    bus(32'h06, 1'b0, 32'd0, 4'hF, rd, lat);
    check("misaligned_noack", lat, 0);

    // single block "abc" with auto start
    wr(O_CTRL, 32'h2);
    load_words(0, 16);
    wait_done(cnt);
    check("abc_busy_cycles", cnt, 82);
    check("abc_irq_rise", {31'd0, irq}, IRQ_EXP);
    chk_dig(0, "abc");
    rd_chk(O_BLK, 32'd1, "abc_blkcnt");
    rd_chk(O_CTRL, 32'h2 | IRQB, "abc_status");
    check("irq_held", {31'd0, irq}, IRQ_EXP);
    wr(O_CTRL, 32'h8);
    check("clr_irq", {31'd0, irq}, 0);
    check("clr_done", {31'd0, done}, 0);

    // two chained blocks
    wr(O_CTRL, 32'h2);
    load_words(16, 16);
    wait_done(cnt);
    load_words(32, 16);
    wait_done(cnt);
    chk_dig(1, "two");
    rd_chk(O_BLK, 32'd2, "two_blkcnt");
    wr(O_CTRL, 32'h8);

    // errors: short START, partial sel, MSG/START/INIT while busy
    wr(O_CTRL, 32'h2);
    load_words(0, 5);
    bus(O_MSG, 1'b1, 32'hDEADBEEF, 4'h7, rd, lat);
    check("partial_sel_ack", lat, 1);
    rd_chk(O_CTRL, 32'h2800, "words5_status");
    wr(O_CTRL, 32'h1);
    check("short_start_idle", {31'd0, busy}, 0);
    rd_chk(O_CTRL, 32'h2800 | 32'h4 | IRQB, "short_start_err");
    rd_chk(32'h10, 32'h67452301, "short_start_dig0");
    wr(O_CTRL, 32'h8);
    rd_chk(O_CTRL, 32'h2800, "clr_err");
    load_words(5, 11);
    wr(O_MSG, 32'h12345678);
    wr(O_CTRL, 32'h1);
    wr(O_CTRL, 32'h2);
    check("busy_during_errs", {31'd0, busy}, 1);
    wait_done(cnt);
    rd_chk(O_CTRL, 32'h2 | 32'h4 | IRQB, "busy_err_status");
    chk_dig(0, "err_abc");
    rd_chk(O_BLK, 32'd1, "err_blkcnt");

    // asynchronous reset at round 40 (done and err still set going in)
    load_words(0, 16);
    repeat (41) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_irq", {31'd0, irq}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_chk(32'h10, 32'h67452301, "midrst_dig0");
    rd_chk(O_BLK, 32'd0, "midrst_blkcnt");
    rd_chk(O_CTRL, 32'h0, "midrst_status");

    // abort at round 40, then a clean block from the unchanged IV
    load_words(0, 16);
    repeat (41) @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 1);
    wr(O_CTRL, 32'h4);
    check("abort_idle", {31'd0, busy}, 0);
    rd_chk(O_CTRL, 32'h0, "abort_status");
    rd_chk(32'h10, 32'h67452301, "abort_dig0");
    rd_chk(O_BLK, 32'd0, "abort_blkcnt");
    load_words(0, 16);
    wait_done(cnt);
    check("post_abort_irq", {31'd0, irq}, IRQ_EXP);
    chk_dig(0, "post_abort");
    rd_chk(O_BLK, 32'd1, "post_abort_blkcnt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
